// File: rtl/am2910_useq.sv
// Am2910-compatible microprogram sequencer. It holds the uPC, the R register/counter
// and an LIFO stack, and each cycle it produces the next microaddress y.
module am2910_useq #(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          cp,
  input  logic          rst_n,
  input  logic [3:0]    i,
  input  logic          ccen_n,
  input  logic          cc_n,
  input  logic          rld_n,
  input  logic          ci,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          full_n,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [3:0] {
    JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
    RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
  } op_e;

  logic [AW-1:0]  upc_q, r_q, r_d;
  logic [SPW-1:0] sp_q, tos_idx;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [AW-1:0]  tos, y_sel;
  logic           pass, rz, push, pop, clr, r_dec, r_ld;

  assign pass    = ccen_n | ~cc_n;
  assign rz      = (r_q == '0);
  assign tos_idx = sp_q - SPW'(1);
  assign tos     = (sp_q == '0) ? '0 : stack_q[tos_idx];

  always_comb begin
    y_sel = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    r_dec = 1'b0;
    r_ld  = 1'b0;
    case (op_e'(i))
      JZ:   begin y_sel = '0; clr = 1'b1; end
      CJS:  if (pass) begin y_sel = d; push = 1'b1; end
      JMAP: y_sel = d;
      CJP:  if (pass) y_sel = d;
      PUSH: begin push = 1'b1; r_ld = pass; end
      JSRP: begin y_sel = pass ? d : r_q; push = 1'b1; end
      CJV:  if (pass) y_sel = d;
      JRP:  y_sel = pass ? d : r_q;
      RFCT: if (!rz) begin y_sel = tos; r_dec = 1'b1; end else pop = 1'b1;
      RPCT: if (!rz) begin y_sel = d; r_dec = 1'b1; end
      CRTN: if (pass) begin y_sel = tos; pop = 1'b1; end
      CJPP: if (pass) begin y_sel = d; pop = 1'b1; end
      LDCT: r_ld = 1'b1;
      LOOP: if (pass) pop = 1'b1; else y_sel = tos;
      CONT: ;
      TWB: begin
        r_dec = !rz;
        if (!rz && !pass) y_sel = tos;
        else begin
          pop = 1'b1;
          if (rz && !pass) y_sel = d;
        end
      end
      default: ;
    endcase
  end

  // R load from d (unconditional or instruction-driven) beats the decrement.
  always_comb begin
    r_d = r_q;
    if (!rld_n || r_ld) r_d = d;
    else if (r_dec)     r_d = r_q - AW'(1);
  end

  assign y      = rst_n ? y_sel : '0;
  assign map_n  = ~(rst_n && i == 4'd2);
  assign vect_n = ~(rst_n && i == 4'd6);
  assign pl_n   = ~(map_n & vect_n);
  assign full_n = (sp_q != SP_FULL);

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      upc_q <= '0;
      r_q   <= '0;
      sp_q  <= '0;
    end else begin
      upc_q <= y + {{(AW-1){1'b0}}, ci};
      r_q   <= r_d;
      if (clr) sp_q <= '0;
      else if (push) begin
        if (sp_q != SP_FULL) begin
          stack_q[sp_q] <= upc_q;
          sp_q          <= sp_q + SPW'(1);
        end else stack_q[DEPTH-1] <= upc_q;
      end else if (pop && sp_q != '0) sp_q <= sp_q - SPW'(1);
    end
  end
endmodule
